stopwatch_ctrl: RTL

Control sequencer for the stopwatch's four-digit BCD counter (0000–9999). Synchronises the start/stop, clear and lap buttons, runs a run/pause/done state machine and a tick prescaler, and issues single-cycle count-enable and clear pulses to the counter. Reads the counter's BCD value back to detect the 9999 limit and drives the display value, with an optional lap hold. Sits between the board buttons and the counter/7-segment path.

---
 rtl/stopwatch_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- control sequencer for a four-digit BCD stopwatch counter.
// Synchronises the start/stop, clear and lap buttons, runs the
// IDLE/RUN/PAUSE/DONE state machine with a tick prescaler, and issues
// single-cycle count-enable / clear pulses to the external BCD counter.
// Optional feature macro: LAP_HOLD_EN (lap-hold display freeze). With the
// macro undefined btn_lap is ignored, lap_active is 0 and disp = digits_in.
module stopwatch_ctrl #(
    parameter int DIV = 500000
) (
    input  logic        clk,
    input  logic        masterreset,
    input  logic        btn_startstop,
    input  logic        btn_clear,
    input  logic        btn_lap,
    input  logic [15:0] digits_in,
    output logic        count_en,
    output logic        count_clr,
    output logic        running,
    output logic        done,
    output logic        lap_active,
    output logic [15:0] disp
);

    localparam int              PW       = $clog2(DIV);
    localparam logic [PW-1:0]   PRE_MAX  = PW'(DIV - 1);
    localparam logic [PW-1:0]   PRE_ZERO = PW'(0);
    localparam logic [PW-1:0]   PRE_ONE  = PW'(1);
    localparam logic [15:0]     LIMIT    = 16'h9999;

`ifdef LAP_HOLD_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Button bundle: bit 0 start/stop, bit 1 clear, bit 2 lap (when enabled)
    logic [NB-1:0] btn_s;
    logic [NB-1:0] meta_r;
    logic [NB-1:0] sync_r;
    logic [NB-1:0] prev_r;
    logic [NB-1:0] evt_r;

`ifdef LAP_HOLD_EN
    assign btn_s = {btn_lap, btn_clear, btn_startstop};
`else
    logic unused_lap_s;
    assign btn_s        = {btn_clear, btn_startstop};
    assign unused_lap_s = btn_lap;
`endif

    state_t        state_r;
    logic [PW-1:0] pre_r;
    logic          count_en_r;
    logic          count_clr_r;
    logic          running_r;
    logic          done_r;

    logic          ss_evt_s;
    logic          clr_evt_s;
    logic          term_s;
    logic          limit_s;
    logic          done_go_s;
    logic          clr_go_s;

    assign ss_evt_s  = evt_r[0];
    assign clr_evt_s = evt_r[1];

    // Two-flop synchroniser plus registered rising-edge detector (one event per press)
    always_ff @(posedge clk or posedge masterreset) begin
        if (masterreset) begin
            meta_r <= '0;
            sync_r <= '0;
            prev_r <= '0;
            evt_r  <= '0;
        end else begin
            meta_r <= btn_s;
            sync_r <= meta_r;
            prev_r <= sync_r;
            evt_r  <= sync_r & ~prev_r;
        end
    end

    // Decode terminal tick, counter limit and the legal clear decision
    always_comb begin
        term_s    = (state_r == ST_RUN) && (pre_r == PRE_MAX);
        limit_s   = (digits_in == LIMIT);
        done_go_s = term_s && limit_s;
        // Clear is only honoured outside RUN; there it also beats start/stop
        clr_go_s  = clr_evt_s && (state_r != ST_RUN);
    end

    // Main sequencer: state, prescaler and registered control outputs
    always_ff @(posedge clk or posedge masterreset) begin
        if (masterreset) begin
            state_r     <= ST_IDLE;
            pre_r       <= PRE_ZERO;
            count_en_r  <= 1'b0;
            count_clr_r <= 1'b0;
            running_r   <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            count_en_r  <= 1'b0;
            count_clr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (clr_go_s) begin
                        count_clr_r <= 1'b1;
                        pre_r       <= PRE_ZERO;
                    end else if (ss_evt_s) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    pre_r <= term_s ? PRE_ZERO : (pre_r + PRE_ONE);
                    if (done_go_s) begin
                        // At 9999 the counter is frozen rather than wrapped
                        state_r   <= ST_DONE;
                        running_r <= 1'b0;
                        done_r    <= 1'b1;
                    end else begin
                        count_en_r <= term_s;
                        if (ss_evt_s) begin
                            state_r   <= ST_PAUSE;
                            running_r <= 1'b0;
                        end
                    end
                end
                ST_PAUSE: begin
                    // Prescaler holds here so a resume loses no partial tick
                    if (clr_go_s) begin
                        count_clr_r <= 1'b1;
                        pre_r       <= PRE_ZERO;
                        state_r     <= ST_IDLE;
                    end else if (ss_evt_s) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (clr_go_s) begin
                        count_clr_r <= 1'b1;
                        pre_r       <= PRE_ZERO;
                        state_r     <= ST_IDLE;
                        done_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pre_r     <= PRE_ZERO;
                    running_r <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign count_en  = count_en_r;
    assign count_clr = count_clr_r;
    assign running   = running_r;
    assign done      = done_r;

`ifdef LAP_HOLD_EN
    logic        lap_evt_s;
    logic        lap_active_r;
    logic [15:0] lap_r;

    assign lap_evt_s = evt_r[2];

    // Lap hold: toggle a frozen copy of the count while RUN or PAUSE
    always_ff @(posedge clk or posedge masterreset) begin
        if (masterreset) begin
            lap_active_r <= 1'b0;
            lap_r        <= 16'h0000;
        end else if (clr_go_s || done_go_s) begin
            lap_active_r <= 1'b0;
        end else if (lap_evt_s && ((state_r == ST_RUN) || (state_r == ST_PAUSE))) begin
            if (lap_active_r) begin
                lap_active_r <= 1'b0;
            end else begin
                lap_active_r <= 1'b1;
                lap_r        <= digits_in;
            end
        end
    end

    assign lap_active = lap_active_r;
    assign disp       = lap_active_r ? lap_r : digits_in;
`else
    assign lap_active = 1'b0;
    assign disp       = digits_in;
`endif

endmodule
